interrupt_example_mem_tester: RTL
=================================

# interrupt_example_mem_tester

Avalon-MM master that exercises the on-chip RAM slave from the initiator side. On a start pulse it writes a generated data pattern over a word range, reads the range back, compares each returned word against the regenerated pattern, and reports pass/fail, error count and first failing address. It sits in the test/interrupt example system beside the CPU, sharing the RAM slave through the interconnect, and raises a level interrupt on completion.

## Interface

- ADDR_W, 15, byte-address width (8192 words × 4 bytes)
- CNT_W, 14, word-count width (0..8192)
- MAX_PENDING, 4, maximum outstanding reads (1..15)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle start request
- base_addr  in  ADDR_W  start byte address; bits [1:0] ignored (treated as 0)
- num_words  in  CNT_W  words to test
- seed  in  32  pattern seed
- irq_clear  in  1  clears irq
- busy  out  1  test in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  last test had zero mismatches
- err_count  out  CNT_W  mismatches in last test, saturating
- first_err_addr  out  ADDR_W  byte address of first mismatch
- irq  out  1  level interrupt, set with done
- avm_address  out  ADDR_W  byte address
- avm_read / avm_write  out  1  commands
- avm_writedata  out  32  write data
- avm_byteenable  out  4  always 4'hF while a command is active, 0 otherwise
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read response strobe

## Operation

- Reset: all outputs 0, FSM IDLE, pending count 0.
- States: IDLE → WRITE → READ → DRAIN → DONE → IDLE.
- IDLE: start=1 latches base_addr, num_words, seed; clears err_count/first_err_addr/pass; goes WRITE. num_words=0 goes directly to DONE, no bus traffic, pass=1. start while busy ignored.
- WRITE: word i at address base + 4·i (mod 2^ADDR_W, wraps silently); data = pattern(i). Command held stable (address, data, write) while avm_waitrequest=1; index advances only on accepted cycle (write & ~waitrequest). After word num_words−1 accepted → READ.
- READ: issues reads for i = 0..num_words−1, same address rule, back-to-back while pending < MAX_PENDING; avm_read deasserts when pending = MAX_PENDING. pending +1 on accepted read, −1 on readdatavalid; both in one cycle → unchanged. After last read accepted → DRAIN.
- Checker: independent response index k; each readdatavalid compares avm_readdata with pattern(k). Mismatch: err_count +1 (saturates at all-ones); first mismatch records base + 4·k. readdatavalid with pending=0 is ignored.
- DRAIN: wait pending=0 → DONE.
- DONE: one cycle; done=1, pass=(err_count==0), irq set; → IDLE. busy low from this cycle.
- irq stays high until irq_clear; irq_clear in same cycle as set: set wins.
- Reset mid-test aborts immediately; no bus command follows deassertion.

## Timing

- start in cycle T → busy=1 and first avm_write asserted in T+1.
- Zero-wait slave: one write per cycle; first read in the cycle after the last accepted write.
- Read latency absorbed via readdatavalid; with 1-cycle latency and MAX_PENDING≥2 one read issued per cycle.
- Total with no wait states, latency 1: 2N + 3 cycles from start to done.
- err_count/first_err_addr update the cycle after the offending readdatavalid.

## Configuration

- MEM_TESTER_LFSR_EN defined: pattern(i) = i-th state of 32-bit Galois LFSR (polynomial 0x80200003) seeded with seed (seed=0 replaced by 1); pattern(0)=seed state.
- Not defined: pattern(i) = seed + i (32-bit wrap). LFSR logic absent.

## Test plan

- Incrementing mode, base 0x0000, N=4, seed 0x1000_0000, ideal RAM → writes 0x10000000..0x10000003 to 0x0,0x4,0x8,0xC; done after 11 cycles; pass=1, err_count=0, irq=1.
- Fault injection: RAM model flips bit 0 of word at 0x0008, N=8 → err_count=1, first_err_addr=0x0008, pass=0.
- Backpressure: waitrequest high 3 cycles on every 2nd command, N=16 → command signals stable while stalled, exactly 16 writes and 16 reads accepted, pass=1.
- Wrap and edge: base 0x7FF8, N=4 → addresses 0x7FF8,0x7FFC,0x0000,0x0004; N=0 → done 2 cycles after start, no avm_read/avm_write.
- Pending limit: response latency 10, MAX_PENDING=4 → never more than 4 outstanding reads.
- Reset during READ with 3 pending → all outputs 0 asynchronously; subsequent start runs clean to pass=1; irq_clear deasserts irq.

Source files
------------

// File: rtl/interrupt_example_mem_tester.sv
// Avalon-MM memory tester.
// On a start pulse it writes a data pattern over a word range, reads the range
// back and compares every returned word. It then reports pass, the error count
// and the first failing address, and raises a level interrupt.
// Build option MEM_TESTER_LFSR_EN: the pattern comes from a 32-bit Galois LFSR
// (polynomial 0x80200003). Without it the pattern is seed + i.
module interrupt_example_mem_tester #(
  parameter int ADDR_W      = 15,
  parameter int CNT_W       = 14,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [31:0]       seed,
  input  logic              irq_clear,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              irq,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [PEND_W-1:0] pending;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  num_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] chk_addr;
  logic [31:0]       wr_data;
  logic [31:0]       chk_data;

  logic              start_ok;
  logic              wr_acc;
  logic              rd_acc;
  logic              chk_fire;
  logic              done_set;
  logic              last_cmd;
  logic              cmd_active;
  logic [ADDR_W-1:0] base_aligned;

  // First pattern word derived from the seed.
  function automatic logic [31:0] pat_first(input logic [31:0] s);
`ifdef MEM_TESTER_LFSR_EN
    // An all-zero state would lock the LFSR, so substitute 1.
    return (s == 32'h0) ? 32'h1 : s;
`else
    return s;
`endif
  endfunction

  // Pattern word i+1 from pattern word i.
  function automatic logic [31:0] pat_next(input logic [31:0] x);
`ifdef MEM_TESTER_LFSR_EN
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
`else
    return x + 32'h1;
`endif
  endfunction

  // Saturating increment for the mismatch counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign base_aligned = {base_addr[ADDR_W-1:2], 2'b00};
  assign start_ok     = (state == S_IDLE) && start;
  assign last_cmd     = (idx == num_r - CNT_W'(1));
  assign wr_acc       = avm_write && !avm_waitrequest;
  assign rd_acc       = avm_read && !avm_waitrequest;
  assign chk_fire     = avm_readdatavalid && (pending != '0);
  assign done_set     = (state == S_DRAIN) && (pending == '0);

  // Bus commands are decoded from registered state only; everything is zero when idle.
  assign avm_write      = (state == S_WRITE);
  assign avm_read       = (state == S_READ) && (pending < PEND_W'(MAX_PENDING));
  assign cmd_active     = avm_write || avm_read;
  assign avm_address    = cmd_active ? cmd_addr : '0;
  assign avm_writedata  = avm_write ? wr_data : 32'h0;
  assign avm_byteenable = cmd_active ? 4'hF : 4'h0;

  // Sequencer: IDLE -> WRITE -> READ -> DRAIN -> DONE, with the status outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            pass <= 1'b0;
            idx  <= '0;
            // A zero-length test has nothing outstanding, so it drops straight
            // into the drain wait and completes the following cycle.
            state <= (num_words == '0) ? S_DRAIN : S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_acc) begin
            if (last_cmd) begin
              idx   <= '0;
              state <= S_READ;
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end
        S_READ: begin
          if (rd_acc) begin
            if (last_cmd) begin
              idx   <= '0;
              state <= S_DRAIN;
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (done_set) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outstanding-read counter: an accept and a response in the same cycle cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      case ({rd_acc, chk_fire})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Response checker: counts mismatches and latches the first failing address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (start_ok) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (chk_fire && (avm_readdata != chk_data)) begin
      err_count <= sat_inc(err_count);
      if (err_count == '0) begin
        first_err_addr <= chk_addr;
      end
    end
  end

  // Completion interrupt: set on completion, held until cleared; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (done_set) begin
      irq <= 1'b1;
    end else if (irq_clear) begin
      irq <= 1'b0;
    end
  end

  // Address and pattern generators for the command side and the checker side.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      num_r    <= num_words;
      base_r   <= base_aligned;
      cmd_addr <= base_aligned;
      chk_addr <= base_aligned;
      wr_data  <= pat_first(seed);
      chk_data <= pat_first(seed);
    end else begin
      if (wr_acc) begin
        cmd_addr <= last_cmd ? base_r : cmd_addr + ADDR_W'(4);
        wr_data  <= pat_next(wr_data);
      end else if (rd_acc) begin
        cmd_addr <= cmd_addr + ADDR_W'(4);
      end
      if (chk_fire) begin
        chk_addr <= chk_addr + ADDR_W'(4);
        chk_data <= pat_next(chk_data);
      end
    end
  end

endmodule
